// File: rtl/branch_resolve_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
//
// Purpose : shared definitions for the execute-stage branch resolver.
//           Holds the control-flow op codes and their width, the resolver
//           FSM state encoding, the default flush length and default
//           datapath widths, plus small op-classification helpers.
// Ports   : none (package).
// Macro   : none (the optional BRANCH_RESOLVE_STATS_EN feature lives in
//           branch_resolve.sv).
// ---------------------------------------------------------------------------
package branch_pkg;

    // Op code field width and encodings. Values 6 and 7 are unused and are
    // treated exactly like NOP by the resolver.
    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 3'd0,
        OP_BNE = 3'd1,
        OP_BLT = 3'd2,
        OP_J   = 3'd3,
        OP_JAL = 3'd4,
        OP_JR  = 3'd5
    } op_e;

    // Resolver FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Default configuration.
    localparam int PC_W_DEFAULT         = 32;
    localparam int IMM_W_DEFAULT        = 17;
    localparam int TGT_W_DEFAULT        = 27;
    localparam int FLUSH_CYCLES_DEFAULT = 2;

    // Flush counter width; enough for the legal FLUSH_CYCLES range 1..7.
    localparam int FLUSH_CNT_W = 3;

    // True for the conditional branches (the ops that consult a compare flag).
    function automatic logic is_cond_branch(input logic [OP_W-1:0] op);
        return (op == OP_BNE) || (op == OP_BLT);
    endfunction

    // True for any op the resolver acts on (everything except NOP and the
    // two unused encodings).
    function automatic logic is_ctrl_op(input logic [OP_W-1:0] op);
        return (op >= OP_BNE) && (op <= OP_JR);
    endfunction

endpackage : branch_pkg

// File: rtl/branch_resolve_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_if
//
// Purpose : bundles the execute-stage request signals (op, PC, immediate,
//           jump target, JR register value, compare flags) with the
//           resolver's responses (ready, redirect, flush, link write).
// Modports:
//   master - execute stage / ALU side: drives the request, observes results
//   slave  - branch_resolve: consumes the request, drives the results
// Signals:
//   ex_valid, ex_op, ex_pc, ex_imm, ex_tgt, ex_rd_val   request
//   is_not_equal, is_less_than                           compare flags
//   ex_ready                                             resolver can accept
//   redirect, redirect_pc                                fetch PC load
//   flush                                                squash fetch/decode
//   link_we, link_data                                   $31 write for JAL
// ---------------------------------------------------------------------------
interface branch_resolve_if
    import branch_pkg::*;
#(
    parameter int PC_W  = PC_W_DEFAULT,
    parameter int IMM_W = IMM_W_DEFAULT,
    parameter int TGT_W = TGT_W_DEFAULT
);

    // Request from execute
    logic              ex_valid;
    logic              ex_ready;
    logic [OP_W-1:0]   ex_op;
    logic [PC_W-1:0]   ex_pc;
    logic [IMM_W-1:0]  ex_imm;
    logic [TGT_W-1:0]  ex_tgt;
    logic [PC_W-1:0]   ex_rd_val;

    // Compare flags from the ALU comparator
    logic              is_not_equal;
    logic              is_less_than;

    // Results toward fetch / pipeline registers / register file
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              flush;
    logic              link_we;
    logic [PC_W-1:0]   link_data;

    modport master (
        output ex_valid,
        output ex_op,
        output ex_pc,
        output ex_imm,
        output ex_tgt,
        output ex_rd_val,
        output is_not_equal,
        output is_less_than,
        input  ex_ready,
        input  redirect,
        input  redirect_pc,
        input  flush,
        input  link_we,
        input  link_data
    );

    modport slave (
        input  ex_valid,
        input  ex_op,
        input  ex_pc,
        input  ex_imm,
        input  ex_tgt,
        input  ex_rd_val,
        input  is_not_equal,
        input  is_less_than,
        output ex_ready,
        output redirect,
        output redirect_pc,
        output flush,
        output link_we,
        output link_data
    );

endinterface : branch_resolve_if

// File: rtl/branch_resolve_target_gen.sv
// ---------------------------------------------------------------------------
// branch_target_gen
//
// Purpose : purely combinational redirect-target selection.
//           BNE/BLT : pc + 1 + sign_ext(imm)
//           J/JAL   : zero_ext(tgt)
//           JR      : rd_val
//           All arithmetic wraps modulo 2^PC_W.
//           Also provides pc + 1, reused as the JAL link value.
// Ports   :
//   op_i        op code (branch_pkg encoding)
//   pc_i        PC of the execute instruction
//   imm_i       branch offset (signed)
//   tgt_i       jump target (unsigned)
//   rd_val_i    register value for JR
//   target_o    selected redirect target
//   pc_plus1_o  pc_i + 1
// ---------------------------------------------------------------------------
module branch_target_gen
    import branch_pkg::*;
#(
    parameter int PC_W  = PC_W_DEFAULT,
    parameter int IMM_W = IMM_W_DEFAULT,
    parameter int TGT_W = TGT_W_DEFAULT
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic [TGT_W-1:0] tgt_i,
    input  logic [PC_W-1:0]  rd_val_i,
    output logic [PC_W-1:0]  target_o,
    output logic [PC_W-1:0]  pc_plus1_o
);

    logic [PC_W-1:0] imm_sext;
    logic [PC_W-1:0] tgt_zext;
    logic [PC_W-1:0] branch_tgt;

    assign imm_sext   = {{(PC_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign tgt_zext   = {{(PC_W-TGT_W){1'b0}}, tgt_i};
    assign pc_plus1_o = pc_i + {{(PC_W-1){1'b0}}, 1'b1};
    assign branch_tgt = pc_plus1_o + imm_sext;

    always_comb begin
        target_o = branch_tgt;
        case (op_i)
            OP_J, OP_JAL: target_o = tgt_zext;
            OP_JR:        target_o = rd_val_i;
            default:      target_o = branch_tgt;
        endcase
    end

endmodule : branch_target_gen

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//
// Purpose : execute-stage control-flow resolver. Decides taken/not-taken for
//           BNE, BLT, J, JAL and JR from the ALU compare flags, and one cycle
//           after a taken accept drives a single-cycle redirect to the fetch
//           PC mux together with a FLUSH_CYCLES-long flush of the fetch and
//           decode pipeline registers. JAL also pulses a link write of pc+1.
//           While flushing the block is not ready; ops presented then are
//           wrong-path and are dropped. Not-taken ops are accepted every
//           cycle with no bubble.
// Ports   :
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   bus            branch_resolve_if.slave (request, flags, results)
//   stat_resolved  [BRANCH_RESOLVE_STATS_EN only] accepted BNE/BLT count
//   stat_taken     [BRANCH_RESOLVE_STATS_EN only] accepted taken BNE/BLT count
// Macro   : BRANCH_RESOLVE_STATS_EN adds the two wrapping 32-bit counters.
// Params  : PC_W, IMM_W, TGT_W widths; FLUSH_CYCLES flush length (1..7).
// ---------------------------------------------------------------------------
module branch_resolve
    import branch_pkg::*;
#(
    parameter int PC_W         = PC_W_DEFAULT,
    parameter int IMM_W        = IMM_W_DEFAULT,
    parameter int TGT_W        = TGT_W_DEFAULT,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    branch_resolve_if.slave       bus
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]           stat_resolved,
    output logic [31:0]           stat_taken
`endif
);

    // The counter holds "flush cycles remaining after this one", so a taken
    // accept loads FLUSH_CYCLES-1 and the FSM leaves FLUSH on the edge after
    // it reads zero.
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e                  state_q;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_q;
    logic                    ex_ready_q;
    logic                    redirect_q;
    logic [PC_W-1:0]         redirect_pc_q;
    logic                    flush_q;
    logic                    link_we_q;
    logic [PC_W-1:0]         link_data_q;

    // ------------------------------------------------------------------
    // Decode of the current execute op
    // ------------------------------------------------------------------
    logic                    accept_d;
    logic                    taken_d;
    logic                    is_jal_d;
    logic [PC_W-1:0]         target_d;
    logic [PC_W-1:0]         pc_plus1_d;

    branch_target_gen #(
        .PC_W  (PC_W),
        .IMM_W (IMM_W),
        .TGT_W (TGT_W)
    ) u_target_gen (
        .op_i       (bus.ex_op),
        .pc_i       (bus.ex_pc),
        .imm_i      (bus.ex_imm),
        .tgt_i      (bus.ex_tgt),
        .rd_val_i   (bus.ex_rd_val),
        .target_o   (target_d),
        .pc_plus1_o (pc_plus1_d)
    );

    // ex_ready_q is only ever high in IDLE, so gating the accept with it
    // also drops every op presented during FLUSH.
    always_comb begin
        accept_d = bus.ex_valid & ex_ready_q & is_ctrl_op(bus.ex_op);
        is_jal_d = (bus.ex_op == OP_JAL);
        taken_d  = 1'b0;
        // Each conditional branch looks only at its own flag.
        case (bus.ex_op)
            OP_BNE:              taken_d = bus.is_not_equal;
            OP_BLT:              taken_d = bus.is_less_than;
            OP_J, OP_JAL, OP_JR: taken_d = 1'b1;
            default:             taken_d = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Resolver FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            flush_cnt_q   <= '0;
            ex_ready_q    <= 1'b1;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
            link_we_q     <= 1'b0;
            link_data_q   <= '0;
        end else begin
            // Redirect and link write are single-cycle pulses.
            redirect_q <= 1'b0;
            link_we_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (accept_d && taken_d) begin
                        state_q       <= ST_FLUSH;
                        flush_cnt_q   <= FLUSH_LOAD;
                        ex_ready_q    <= 1'b0;
                        flush_q       <= 1'b1;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= target_d;
                        if (is_jal_d) begin
                            link_we_q   <= 1'b1;
                            link_data_q <= pc_plus1_d;
                        end
                    end
                end

                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_q    <= ST_IDLE;
                        ex_ready_q <= 1'b1;
                        flush_q    <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - FLUSH_CNT_W'(1);
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    ex_ready_q <= 1'b1;
                    flush_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ex_ready    = ex_ready_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.flush       = flush_q;
    assign bus.link_we     = link_we_q;
    assign bus.link_data   = link_data_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    // ------------------------------------------------------------------
    // Conditional-branch statistics; jumps are deliberately not counted.
    // ------------------------------------------------------------------
    logic [31:0] stat_resolved_q;
    logic [31:0] stat_taken_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_resolved_q <= '0;
            stat_taken_q    <= '0;
        end else if (accept_d && is_cond_branch(bus.ex_op)) begin
            stat_resolved_q <= stat_resolved_q + 32'd1;
            if (taken_d) begin
                stat_taken_q <= stat_taken_q + 32'd1;
            end
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_taken    = stat_taken_q;
`endif

endmodule : branch_resolve

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage consumer of the 32-bit equality and less-than compare flags produced by the ALU comparator.
- Decides taken/not-taken for bne, blt, j, jal and jr; computes the redirect PC; produces link data for jal.
- Drives a registered redirect to the fetch PC mux and a multi-cycle flush to the fetch and decode pipeline registers.
- Sits between the ALU compare outputs and the PC-select / pipeline-register control.

Parameters:
- PC_W, 32, width of PC and all address datapaths.
- IMM_W, 17, width of branch immediate N; sign-extended to PC_W.
- TGT_W, 27, width of jump target T; zero-extended to PC_W.
- FLUSH_CYCLES, 2, number of cycles flush is held after a taken redirect; legal range 1..7.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  instruction in execute is valid.
- ex_ready  out  1  block can accept a control-flow op this cycle.
- ex_op  in  3  op code from branch_pkg: NOP=0, BNE=1, BLT=2, J=3, JAL=4, JR=5; 6 and 7 are treated as NOP.
- ex_pc  in  PC_W  PC of the execute instruction (word addressed).
- ex_imm  in  IMM_W  branch offset N.
- ex_tgt  in  TGT_W  jump target T.
- ex_rd_val  in  PC_W  register value used by JR.
- is_not_equal  in  1  compare flag: operand A != operand B.
- is_less_than  in  1  compare flag: A < B (signed).
- redirect  out  1  one-cycle pulse; fetch loads redirect_pc.
- redirect_pc  out  PC_W  new PC; valid while redirect=1.
- flush  out  1  squash fetch/decode pipeline registers.
- link_we  out  1  write $31, one-cycle pulse.
- link_data  out  PC_W  value ex_pc+1 for JAL.

Behaviour:
- Accept condition: ex_valid & ex_ready & (ex_op != NOP).
- Taken rules: BNE if is_not_equal; BLT if is_less_than; J, JAL and JR always taken.
- Target computation (all arithmetic mod 2^PC_W, wrap silently):
  - BNE/BLT: ex_pc + 1 + sign_ext(ex_imm).
  - J/JAL: zero_ext(ex_tgt).
  - JR: ex_rd_val.
- Latency: all outputs are registered; they appear one cycle after the accept edge.
- Taken accept:
  - redirect=1 and redirect_pc=target for exactly 1 cycle.
  - flush=1 for FLUSH_CYCLES cycles, starting the same cycle as redirect.
- Not-taken accept: no redirect, no flush.
- JAL additionally pulses link_we=1 with link_data=ex_pc+1, in the same cycle as redirect.
- FSM states:
  - IDLE: ex_ready=1. A taken accept moves to FLUSH and loads flush_cnt=FLUSH_CYCLES-1. A not-taken accept or no accept stays in IDLE.
  - FLUSH: ex_ready=0 and flush=1. Each cycle flush_cnt decrements; at flush_cnt==0 return to IDLE. Ops presented during FLUSH are ignored (they are squashed wrong-path instructions).
- Back-to-back not-taken ops are accepted every cycle with no bubble.
- Simultaneous events: is_not_equal and is_less_than are only examined for the op that selects them; the other flag is don't-care.
- Reset values: redirect=0, redirect_pc=0, flush=0, link_we=0, link_data=0, ex_ready=1 (state IDLE, flush_cnt=0).
- Reset asserted mid-FLUSH: the next edge forces IDLE and clears all outputs, including any pending redirect.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- With the macro defined:
  - Adds outputs stat_resolved[31:0] and stat_taken[31:0].
  - stat_resolved increments on every accepted BNE/BLT; stat_taken increments on every accepted taken BNE/BLT.
  - Both counters wrap at 2^32 and are cleared by reset.
  - Jumps are not counted.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- branch_pkg holds:
  - op code constants NOP..JR and the op width of 3;
  - the FSM state encoding IDLE/FLUSH;
  - the default FLUSH_CYCLES.
- One sub-module, branch_target_gen: purely combinational selection of the sign/zero-extended target; instantiated once.

Test Plan:
- Reset mid-flush: reset=1 during cycle 2 of the flush of a taken BNE -> next cycle flush=0, redirect=0, ex_ready=1.
- BNE taken: ex_pc=100, ex_imm=-4, is_not_equal=1 -> next cycle redirect=1, redirect_pc=97; flush high 2 cycles; ex_ready low 2 cycles.
- BLT not taken, back-to-back: BLT with is_less_than=0 on 3 consecutive cycles -> redirect and flush stay 0; ex_ready stays 1.
- JAL: ex_pc=0x40, ex_tgt=0x1234 -> redirect_pc=0x1234, link_we=1, link_data=0x41 in the same cycle.
- Wrap and wrong-path squash:
  - JR with ex_rd_val=0xFFFFFFFF -> redirect_pc=0xFFFFFFFF.
  - Then BNE with ex_pc=0xFFFFFFFF, imm=0: it arrives during FLUSH and is ignored; re-issued after FLUSH it gives redirect_pc=0x00000000 (wrap).
- Stats (BRANCH_RESOLVE_STATS_EN defined): 5 BNE of which 3 taken, plus 2 J -> stat_resolved=5, stat_taken=3.
